// File: rtl/sci_frame_sched.sv
// Read-side frame scheduler: drains the SCI byte FIFO into header/len/payload frames for the UART.
// Build option: define SCI_FRAME_CKSUM_EN to append a mod-256 checksum byte (len + payload) to each frame.

module sci_frame_sched #(
  parameter int unsigned PTRWIDTH = 9,
  parameter int unsigned MAX_LEN  = 16,
  parameter int unsigned TIMEOUT  = 1000,
  parameter logic [7:0]  HEADER   = 8'hA5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fifo_empty,
  input  logic [PTRWIDTH-1:0] fifo_usedw,
  input  logic [7:0]          fifo_dout,
  input  logic                fifo_valid,
  output logic                fifo_load,
  input  logic                tx_busy,
  output logic                tx_start,
  output logic [7:0]          tx_data,
  output logic                busy,
  output logic                frame_done
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] HDR       = 4'd1;
  localparam logic [3:0] LEN       = 4'd2;
  localparam logic [3:0] FETCH     = 4'd3;
  localparam logic [3:0] WAIT_DATA = 4'd4;
  localparam logic [3:0] PAYLOAD   = 4'd5;
  localparam logic [3:0] WAIT_ACK  = 4'd7;
  localparam logic [3:0] WAIT_TX   = 4'd8;
`ifdef SCI_FRAME_CKSUM_EN
  localparam logic [3:0] CKS       = 4'd6;
`endif

  // Which byte is in flight, so WAIT_TX knows where to go next.
  localparam logic [1:0] K_HDR = 2'd0;
  localparam logic [1:0] K_LEN = 2'd1;
  localparam logic [1:0] K_PAY = 2'd2;

  logic [3:0]       state, state_nxt;
  logic [1:0]       kind, kind_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       len, len_nxt;
  logic [7:0]       rem, rem_nxt;
  logic             fifo_load_nxt;
  logic             tx_start_nxt;
  logic [7:0]       tx_data_nxt;
  logic             busy_nxt;
  logic             frame_done_nxt;
`ifdef SCI_FRAME_CKSUM_EN
  logic [7:0]       cks, cks_nxt;
`endif

  logic       full_hit;
  logic       tmo_hit;
  logic [7:0] start_len;

  assign full_hit  = (32'(fifo_usedw) >= MAX_LEN);
  assign tmo_hit   = !fifo_empty && (32'(cnt) == TIMEOUT - 32'd1);
  assign start_len = full_hit ? 8'(MAX_LEN) : 8'(fifo_usedw);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      kind       <= K_HDR;
      cnt        <= '0;
      len        <= 8'h00;
      rem        <= 8'h00;
      fifo_load  <= 1'b0;
      tx_start   <= 1'b0;
      tx_data    <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef SCI_FRAME_CKSUM_EN
      cks        <= 8'h00;
`endif
    end else begin
      state      <= state_nxt;
      kind       <= kind_nxt;
      cnt        <= cnt_nxt;
      len        <= len_nxt;
      rem        <= rem_nxt;
      fifo_load  <= fifo_load_nxt;
      tx_start   <= tx_start_nxt;
      tx_data    <= tx_data_nxt;
      busy       <= busy_nxt;
      frame_done <= frame_done_nxt;
`ifdef SCI_FRAME_CKSUM_EN
      cks        <= cks_nxt;
`endif
    end
  end

  // Next state plus next values of every registered output; strobes default low.
  always_comb begin
    state_nxt      = state;
    kind_nxt       = kind;
    cnt_nxt        = cnt;
    len_nxt        = len;
    rem_nxt        = rem;
    fifo_load_nxt  = 1'b0;
    tx_start_nxt   = 1'b0;
    tx_data_nxt    = tx_data;
    busy_nxt       = busy;
    frame_done_nxt = 1'b0;
`ifdef SCI_FRAME_CKSUM_EN
    cks_nxt        = cks;
`endif
    case (state)
      IDLE: begin
        if (full_hit || tmo_hit) begin
          len_nxt   = start_len;
          rem_nxt   = start_len;
          cnt_nxt   = '0;
          busy_nxt  = 1'b1;
          state_nxt = HDR;
`ifdef SCI_FRAME_CKSUM_EN
          cks_nxt   = 8'h00;
`endif
        end else if (fifo_empty) begin
          cnt_nxt = '0;
        end else if (32'(cnt) < TIMEOUT) begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      HDR: begin
        if (!tx_busy) begin
          tx_data_nxt  = HEADER;
          tx_start_nxt = 1'b1;
          kind_nxt     = K_HDR;
          state_nxt    = WAIT_ACK;
        end
      end
      LEN: begin
        tx_data_nxt  = len;
        tx_start_nxt = 1'b1;
        kind_nxt     = K_LEN;
        state_nxt    = WAIT_ACK;
`ifdef SCI_FRAME_CKSUM_EN
        cks_nxt      = cks + len;
`endif
      end
      FETCH: begin
        state_nxt = WAIT_DATA;
      end
      // Launch the byte the cycle after it arrives so tx_data and tx_start change together.
      WAIT_DATA: begin
        if (fifo_valid) begin
          tx_data_nxt  = fifo_dout;
          tx_start_nxt = 1'b1;
          rem_nxt      = rem - 8'd1;
          kind_nxt     = K_PAY;
          state_nxt    = PAYLOAD;
`ifdef SCI_FRAME_CKSUM_EN
          cks_nxt      = cks + fifo_dout;
`endif
        end
      end
      PAYLOAD: begin
        state_nxt = WAIT_ACK;
      end
`ifdef SCI_FRAME_CKSUM_EN
      CKS: begin
        tx_data_nxt  = cks;
        tx_start_nxt = 1'b1;
        kind_nxt     = 2'd3;
        state_nxt    = WAIT_ACK;
      end
`endif
      WAIT_ACK: begin
        state_nxt = WAIT_TX;
      end
      WAIT_TX: begin
        if (!tx_busy) begin
          case (kind)
            K_HDR: state_nxt = LEN;
            K_LEN: begin
              fifo_load_nxt = 1'b1;
              state_nxt     = FETCH;
            end
            K_PAY: begin
              if (rem != 8'd0) begin
                fifo_load_nxt = 1'b1;
                state_nxt     = FETCH;
              end else begin
`ifdef SCI_FRAME_CKSUM_EN
                state_nxt      = CKS;
`else
                frame_done_nxt = 1'b1;
                busy_nxt       = 1'b0;
                state_nxt      = IDLE;
`endif
              end
            end
            default: begin
              frame_done_nxt = 1'b1;
              busy_nxt       = 1'b0;
              state_nxt      = IDLE;
            end
          endcase
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule
